// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
//   DefaultWidth / DefaultDepth : default data width and entry count
//   cnt_width()                 : bit width needed to hold an occupancy of 0..depth
//   fifo_status_t               : packed view of the FIFO status flags
package sync_fifo_pkg;

   localparam int unsigned DefaultWidth = 16;
   localparam int unsigned DefaultDepth = 16;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM used as FIFO storage.
// Macro SYNC_FIFO_FWFT_EN selects an asynchronous read port; otherwise the read
// port is registered, loads on re and resets to zero. Memory contents are never reset.
//   clk, rst       : clock, synchronous active-high reset (read register only)
//   we/waddr/wdata : synchronous write port
//   re/raddr/rdata : read port
module fifo_ram #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is visible combinationally; rst and re have no role here.
   logic unused_ctrl;
   assign unused_ctrl = rst ^ re;

   always_comb begin
      rdata = mem_q[raddr];
   end
`else
   logic [WIDTH-1:0] rdata_d, rdata_q;

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      rdata = rdata_q;
   end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
// Macro SYNC_FIFO_FWFT_EN enables first-word-fall-through output (dout shows the
// head word while not empty, zero when empty); default is a registered read.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : clears pointers/count, holds dout and error flags
//   clr_err         : clears sticky error flags (a same-cycle new error wins)
//   wr_en, din      : write request and data
//   rd_en, dout     : read request (pop in FWFT) and data
//   full, empty, almost_full, almost_empty, count : occupancy status
//   overflow, underflow : sticky rejected-access flags
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = DefaultWidth,
   parameter int unsigned DEPTH     = DefaultDepth,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter int unsigned AE_THRESH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       clr_err,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           din,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);

   logic [AW-1:0] wr_ptr_d, wr_ptr_q;
   logic [AW-1:0] rd_ptr_d, rd_ptr_q;
   logic [CW-1:0] count_d, count_q;
   logic          overflow_d, overflow_q;
   logic          underflow_d, underflow_q;

   logic          full_w, empty_w;
   logic          wr_acc, rd_acc, ovf_set, unf_set;
   logic [WIDTH-1:0] ram_rdata;

   always_comb begin
      full_w  = (count_q == CW'(DEPTH));
      empty_w = (count_q == '0);
      // Flush drops any same-cycle access without flagging it.
      wr_acc  = wr_en && !full_w  && !flush;
      rd_acc  = rd_en && !empty_w && !flush;
      ovf_set = wr_en && full_w   && !flush;
      unf_set = rd_en && empty_w  && !flush;
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer wrap is the natural overflow.
         if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
         if (wr_acc && !rd_acc) count_d = count_q + CW'(1);
         if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
         if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
         end
         if (ovf_set) overflow_d  = 1'b1;
         if (unf_set) underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (din),
      .re    (rd_acc),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      full         = full_w;
      empty        = empty_w;
      almost_full  = (count_q >= CW'(AF_THRESH));
      almost_empty = (count_q <= CW'(AE_THRESH));
      count        = count_q;
      overflow     = overflow_q;
      underflow    = underflow_q;
`ifdef SYNC_FIFO_FWFT_EN
      dout         = empty_w ? '0 : ram_rdata;
`else
      dout         = ram_rdata;
`endif
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=8, WIDTH=16, AF=6, AE=2).
// A queue-based reference model predicts every output after each clock edge.
module tb_sync_fifo_param;

   localparam int unsigned W  = 16;
   localparam int unsigned D  = 8;
   localparam int unsigned AF = 6;
   localparam int unsigned AE = 2;

   logic          clk = 1'b0;
   logic          rst, flush, clr_err, wr_en, rd_en;
   logic [W-1:0]  din, dout;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0]    count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [W-1:0] mq[$];
   logic [W-1:0] m_dout = '0;
   logic         m_ovf  = 1'b0;
   logic         m_unf  = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_param #(
      .WIDTH     (W),
      .DEPTH     (D),
      .AF_THRESH (AF),
      .AE_THRESH (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .clr_err      (clr_err),
      .wr_en        (wr_en),
      .din          (din),
      .rd_en        (rd_en),
      .dout         (dout),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic w, input logic [W-1:0] d, input logic r,
                             input logic f, input logic c, input logic rs);
      int n;
      n = mq.size();
      if (rs) begin
         mq.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else if (f) begin
         mq.delete();
      end else begin
         if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         if (w && n == D) m_ovf = 1'b1;
         if (r && n == 0) m_unf = 1'b1;
         if (r && n > 0) m_dout = mq.pop_front();
         if (w && n < D) mq.push_back(d);
      end
   endtask

   task automatic compare_all();
      int n;
      logic [W-1:0] exp_dout;
      n = mq.size();
`ifdef SYNC_FIFO_FWFT_EN
      exp_dout = (n > 0) ? mq[0] : '0;
`else
      exp_dout = m_dout;
`endif
      check("dout",         32'(dout),         32'(exp_dout));
      check("count",        32'(count),        32'(n));
      check("full",         32'(full),         32'(n == D));
      check("empty",        32'(empty),        32'(n == 0));
      check("almost_full",  32'(almost_full),  32'(n >= AF));
      check("almost_empty", 32'(almost_empty), 32'(n <= AE));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("underflow",    32'(underflow),    32'(m_unf));
   endtask

   task automatic step(input logic w, input logic [W-1:0] d, input logic r,
                       input logic f, input logic c, input logic rs);
      wr_en   = w;
      din     = d;
      rd_en   = r;
      flush   = f;
      clr_err = c;
      rst     = rs;
      @(posedge clk);
      model_edge(w, d, r, f, c, rs);
      #1;
      compare_all();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
      @(negedge clk);
      step(0, 16'h0, 0, 0, 0, 1);
      step(0, 16'h0, 0, 0, 0, 0);

      // Fill with 0x1111..0x8888, then drain in order.
      for (int k = 1; k <= 8; k++) step(1, W'(16'h1111 * k), 0, 0, 0, 0);
      // Write while full: dropped, overflow set; then clear.
      step(1, 16'hDEAD, 0, 0, 0, 0);
      step(0, 16'h0, 0, 0, 1, 0);
      for (int k = 0; k < 8; k++) step(0, 16'h0, 1, 0, 0, 0);
      // Read while empty: underflow, dout held.
      step(0, 16'h0, 1, 0, 0, 0);
      step(0, 16'h0, 0, 0, 0, 0);
      step(0, 16'h0, 0, 0, 1, 0);

      // Count 4, simultaneous read/write across pointer wrap.
      for (int k = 0; k < 4; k++) step(1, W'(16'h0100 + k), 0, 0, 0, 0);
      for (int k = 0; k < 20; k++) step(1, W'(k), 1, 0, 0, 0);
      // Full with wr+rd: read accepted, write rejected.
      for (int k = 0; k < 4; k++) step(1, W'(16'h0200 + k), 0, 0, 0, 0);
      step(1, 16'hBEEF, 1, 0, 0, 0);
      // Empty-side wr+rd after drain: write accepted, underflow set.
      for (int k = 0; k < 7; k++) step(0, 16'h0, 1, 0, 0, 0);
      step(1, 16'h7777, 1, 0, 0, 0);
      step(0, 16'h0, 0, 0, 1, 0);
      step(0, 16'h0, 1, 0, 0, 0);

      // Count 5, flush with write pending: no error, then single word round trip.
      for (int k = 0; k < 5; k++) step(1, W'(16'h0300 + k), 0, 0, 0, 0);
      step(1, 16'hFFFF, 1, 1, 0, 0);
      step(1, 16'hA5A5, 0, 0, 0, 0);
      step(0, 16'h0, 1, 0, 0, 0);

      // Reset mid-burst discards contents.
      for (int k = 0; k < 3; k++) step(1, W'(16'h0400 + k), 0, 0, 0, 0);
      step(1, 16'h0bad, 1, 0, 0, 1);
      step(1, 16'h0C0C, 0, 0, 0, 0);
      step(0, 16'h0, 1, 0, 0, 0);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         logic w, r, f, c, rs;
         w  = ($urandom_range(0, 99) < 55);
         r  = ($urandom_range(0, 99) < 50);
         f  = ($urandom_range(0, 31) == 0);
         c  = !f && ($urandom_range(0, 7) == 0);
         rs = ($urandom_range(0, 99) == 0);
         step(w, W'($urandom), r, f, c, rs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
